// File: rtl/freq_checker_pkg.sv
// Shared types for the frequency checker: gate-window FSM state encoding.
package freq_checker_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } freq_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input followed by a rising-edge detector.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_out
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchroniser chain plus the previous-value flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise_out = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/freq_checker.sv
// Gate-window frequency checker: counts synchronised rising edges of meas_in over a fixed window.
module freq_checker #(
    parameter int WINDOW_CYCLES = 100000,
    parameter int CNT_W         = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_in,
    input  logic             meas_in,
    input  logic [CNT_W-1:0] expected_in,
    input  logic [CNT_W-1:0] tol_in,
    output logic [CNT_W-1:0] count_out,
    output logic             valid_out,
    output logic             in_range_out,
    output logic             overflow_out,
    output logic             busy_out
);
    import freq_checker_pkg::*;

    localparam int               WIN_W    = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    freq_state_t      state_r;
    logic [WIN_W-1:0] win_cnt_r;
    logic [CNT_W-1:0] edge_cnt_r;
    logic             sat_r;
    logic [CNT_W-1:0] count_r;
    logic             valid_r;
    logic             in_range_r;
    logic             overflow_r;
    logic             busy_r;

    logic             rise_s;
    logic [CNT_W-1:0] edge_next_s;
    logic             sat_next_s;
    logic [CNT_W:0]   diff_s;
    logic             in_range_next_s;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(meas_in),
        .rise_out(rise_s)
    );

    // Next edge count including this cycle's edge, and tolerance check on that value
    always_comb begin
        edge_next_s     = edge_cnt_r;
        sat_next_s      = sat_r;
        diff_s          = '0;
        in_range_next_s = 1'b0;
        if (rise_s) begin
            if (edge_cnt_r == CNT_MAX) begin
                sat_next_s = 1'b1;
            end else begin
                edge_next_s = edge_cnt_r + CNT_W'(1);
            end
        end else begin
            edge_next_s = edge_cnt_r;
        end
        // Widened by one bit so the absolute difference never wraps
        if (edge_next_s >= expected_in) begin
            diff_s = {1'b0, edge_next_s} - {1'b0, expected_in};
        end else begin
            diff_s = {1'b0, expected_in} - {1'b0, edge_next_s};
        end
        in_range_next_s = ~sat_next_s & (diff_s <= {1'b0, tol_in});
    end

    // Window FSM with registered results; valid_r is high only during DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            win_cnt_r  <= '0;
            edge_cnt_r <= '0;
            sat_r      <= 1'b0;
            count_r    <= '0;
            valid_r    <= 1'b0;
            in_range_r <= 1'b0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (en_in) begin
                        state_r    <= MEASURE;
                        win_cnt_r  <= WIN_LOAD;
                        edge_cnt_r <= '0;
                        sat_r      <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (!en_in) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        edge_cnt_r <= edge_next_s;
                        sat_r      <= sat_next_s;
                        if (win_cnt_r == '0) begin
                            state_r    <= DONE;
                            busy_r     <= 1'b0;
                            valid_r    <= 1'b1;
                            count_r    <= edge_next_s;
                            overflow_r <= sat_next_s;
                            in_range_r <= in_range_next_s;
                        end else begin
                            win_cnt_r <= win_cnt_r - WIN_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign count_out    = count_r;
    assign valid_out    = valid_r;
    assign in_range_out = in_range_r;
    assign overflow_out = overflow_r;
    assign busy_out     = busy_r;

endmodule

// File: tb/tb_freq_checker.sv
// Self-checking bench for freq_checker: two instances (CNT_W=8 and CNT_W=5) share one stimulus.
module tb_freq_checker;

    localparam int W    = 100;
    localparam int SYNC = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       meas  = 1'b0;
    logic [7:0] exp8  = 8'd0;
    logic [7:0] tol8  = 8'd0;
    logic [4:0] exp5  = 5'd0;
    logic [4:0] tol5  = 5'd0;

    logic [7:0] cnt8;
    logic       valid8, inr8, ovf8, busy8;
    logic [4:0] cnt5;
    logic       valid5, inr5, ovf5, busy5;

    int chk  = 0;
    int pass = 0;
    int cyc  = 0;
    bit samp [0:32767];
    int meas_mode = 0;
    int per       = 10;
    int ph        = 0;
    int pulse_at  = 0;

    always #5 clk = ~clk;

    freq_checker #(.WINDOW_CYCLES(W), .CNT_W(8), .SYNC_STAGES(SYNC)) dut8 (
        .clk(clk), .rst_n(rst_n), .en_in(en), .meas_in(meas),
        .expected_in(exp8), .tol_in(tol8), .count_out(cnt8), .valid_out(valid8),
        .in_range_out(inr8), .overflow_out(ovf8), .busy_out(busy8)
    );

    freq_checker #(.WINDOW_CYCLES(W), .CNT_W(5), .SYNC_STAGES(SYNC)) dut5 (
        .clk(clk), .rst_n(rst_n), .en_in(en), .meas_in(meas),
        .expected_in(exp5), .tol_in(tol5), .count_out(cnt5), .valid_out(valid5),
        .in_range_out(inr5), .overflow_out(ovf5), .busy_out(busy5)
    );

    // Record the value of meas_in seen at every posedge, indexed by edge number
    always @(posedge clk) begin
        samp[cyc[14:0]] <= meas;
        cyc             <= cyc + 1;
    end

    // meas_in changes only on negedges; cyc here is the index of the next posedge
    always @(negedge clk) begin
        case (meas_mode)
            1:       meas = ((cyc + ph) % per) < (per / 2);
            2:       meas = (cyc >= pulse_at) && (cyc < pulse_at + 8);
            default: meas = 1'b0;
        endcase
    end

    // Reference: a rise first sampled at edge c is counted at edge c+SYNC; a window
    // that starts at edge e0 counts the edges landing on e0+1 .. e0+W.
    function automatic int raw_edges(input int e0);
        int n = 0;
        for (int t = e0 + 1; t <= e0 + W; t++) begin
            if (t - SYNC >= 1 && samp[15'(t - SYNC)] && !samp[15'(t - SYNC - 1)]) n++;
        end
        return n;
    endfunction

    function automatic int sat_cnt(input int raw, input int maxv);
        return (raw > maxv) ? maxv : raw;
    endfunction

    function automatic bit model_inr(input int raw, input int maxv, input int e, input int t);
        if (raw > maxv) return 1'b0;
        return (((raw >= e) ? raw - e : e - raw) <= t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        meas_mode = 0;
        en        = 1'b0;
        rst_n     = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        chk++;
        if ({cnt8, valid8, inr8, ovf8, busy8} !== 12'd0) $display("FAIL reset_dut8: got %h want 000", {cnt8, valid8, inr8, ovf8, busy8});
        else pass++;
        chk++;
        if ({cnt5, valid5, inr5, ovf5, busy5} !== 9'd0) $display("FAIL reset_dut5: got %h want 000", {cnt5, valid5, inr5, ovf5, busy5});
        else pass++;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_periodic();
        int e0, rel;
        apply_reset();
        exp8 = 8'd10; tol8 = 8'd0; exp5 = 5'd10; tol5 = 5'd0;
        per = 10; ph = int'($urandom_range(0, 9)); meas_mode = 1;
        en = 1'b1;
        e0 = cyc;
        for (int k = 0; k < 2 * (W + 1); k++) begin
            tick();
            rel = (cyc - 1 - e0) % (W + 1);
            chk++;
            if (valid8 !== (rel == W)) $display("FAIL periodic_valid: edge %0d got %0b want %0b", cyc - 1, valid8, rel == W);
            else pass++;
            chk++;
            if (busy8 !== (rel < W)) $display("FAIL periodic_busy: edge %0d got %0b want %0b", cyc - 1, busy8, rel < W);
            else pass++;
            if (rel == W) begin
                chk++;
                if ({cnt8, ovf8, inr8} !== {8'd10, 1'b0, 1'b1}) $display("FAIL periodic_result: got cnt=%0d ovf=%0b inr=%0b want cnt=10 ovf=0 inr=1", cnt8, ovf8, inr8);
                else pass++;
            end
        end
        en = 1'b0;
    endtask

    task automatic test_zero();
        int e0, rel, wi;
        apply_reset();
        exp8 = 8'd1; tol8 = 8'd0; exp5 = 5'd1; tol5 = 5'd0;
        en = 1'b1;
        e0 = cyc;
        for (int k = 0; k < 2 * (W + 1); k++) begin
            tick();
            rel = (cyc - 1 - e0) % (W + 1);
            wi  = (cyc - 1 - e0) / (W + 1);
            if (wi == 1 && rel == 50) begin
                tol8 = 8'd1; tol5 = 5'd1;
            end
            if (rel == W) begin
                chk++;
                if ({cnt8, ovf8, inr8} !== {8'd0, 1'b0, wi == 1}) $display("FAIL zero_dut8 win%0d: got cnt=%0d ovf=%0b inr=%0b want cnt=0 ovf=0 inr=%0b", wi, cnt8, ovf8, inr8, wi == 1);
                else pass++;
                chk++;
                if ({cnt5, ovf5, inr5} !== {5'd0, 1'b0, wi == 1}) $display("FAIL zero_dut5 win%0d: got cnt=%0d ovf=%0b inr=%0b want cnt=0 ovf=0 inr=%0b", wi, cnt5, ovf5, inr5, wi == 1);
                else pass++;
            end
        end
        en = 1'b0;
    endtask

    task automatic test_overflow();
        apply_reset();
        exp8 = 8'd50; tol8 = 8'd0; exp5 = 5'd31; tol5 = 5'd31;
        per = 2; ph = 0; meas_mode = 1;
        en = 1'b1;
        repeat (W + 1) tick();
        chk++;
        if ({cnt8, ovf8, inr8, valid8} !== {8'd50, 1'b0, 1'b1, 1'b1}) $display("FAIL ovf_dut8: got cnt=%0d ovf=%0b inr=%0b v=%0b want 50/0/1/1", cnt8, ovf8, inr8, valid8);
        else pass++;
        chk++;
        if ({cnt5, ovf5, inr5, valid5} !== {5'd31, 1'b1, 1'b0, 1'b1}) $display("FAIL ovf_dut5: got cnt=%0d ovf=%0b inr=%0b v=%0b want 31/1/0/1", cnt5, ovf5, inr5, valid5);
        else pass++;
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int e0, rel, wi, raw, ex, tl;
        apply_reset();
        per = 7; ph = 0; meas_mode = 1;
        en = 1'b1;
        e0 = cyc;
        for (int k = 0; k < 5 * (W + 1); k++) begin
            tick();
            rel = (cyc - 1 - e0) % (W + 1);
            wi  = (cyc - 1 - e0) / (W + 1);
            if (rel == 5) begin
                per = (wi == 4) ? 2 : int'($urandom_range(3, 24));
                ph  = int'($urandom_range(0, 23));
            end
            if (rel == 60) begin
                ex = W / per + int'($urandom_range(0, 4)) - 2;
                if (ex < 0) ex = 0;
                tl = int'($urandom_range(0, 2));
                exp8 = 8'(ex); tol8 = 8'(tl); exp5 = 5'(ex); tol5 = 5'(tl);
            end
            chk++;
            if (valid8 !== (rel == W)) $display("FAIL b2b_valid: edge %0d got %0b want %0b", cyc - 1, valid8, rel == W);
            else pass++;
            if (rel == W) begin
                raw = raw_edges(e0 + wi * (W + 1));
                chk++;
                if ({cnt8, ovf8, inr8} !== {8'(sat_cnt(raw, 255)), raw > 255, model_inr(raw, 255, int'(exp8), int'(tol8))})
                    $display("FAIL b2b_dut8 win%0d: got cnt=%0d ovf=%0b inr=%0b want cnt=%0d ovf=%0b inr=%0b", wi, cnt8, ovf8, inr8,
                             sat_cnt(raw, 255), raw > 255, model_inr(raw, 255, int'(exp8), int'(tol8)));
                else pass++;
                chk++;
                if ({cnt5, ovf5, inr5} !== {5'(sat_cnt(raw, 31)), raw > 31, model_inr(raw, 31, int'(exp5), int'(tol5))})
                    $display("FAIL b2b_dut5 win%0d: got cnt=%0d ovf=%0b inr=%0b want cnt=%0d ovf=%0b inr=%0b", wi, cnt5, ovf5, inr5,
                             sat_cnt(raw, 31), raw > 31, model_inr(raw, 31, int'(exp5), int'(tol5)));
                else pass++;
            end
        end
        en = 1'b0;
    endtask

    task automatic test_en_drop();
        bit seen_valid;
        apply_reset();
        exp8 = 8'd25; tol8 = 8'd0; exp5 = 5'd25; tol5 = 5'd0;
        per = 4; ph = int'($urandom_range(0, 3)); meas_mode = 1;
        en = 1'b1;
        repeat (W + 1) tick();
        chk++;
        if ({cnt8, ovf8, inr8} !== {8'd25, 1'b0, 1'b1}) $display("FAIL drop_first: got cnt=%0d ovf=%0b inr=%0b want 25/0/1", cnt8, ovf8, inr8);
        else pass++;
        repeat (50) tick();
        chk++;
        if (busy8 !== 1'b1) $display("FAIL drop_busy_before: got %0b want 1", busy8);
        else pass++;
        en   = 1'b0;
        exp8 = 8'd0;
        tick();
        chk++;
        if ({busy8, valid8} !== 2'b00) $display("FAIL drop_busy_after: got busy=%0b valid=%0b want 0/0", busy8, valid8);
        else pass++;
        seen_valid = 1'b0;
        for (int k = 0; k < W + 10; k++) begin
            tick();
            if (valid8 === 1'b1 || busy8 === 1'b1) seen_valid = 1'b1;
        end
        chk++;
        if (seen_valid !== 1'b0) $display("FAIL drop_no_valid: got activity=%0b want 0", seen_valid);
        else pass++;
        chk++;
        if ({cnt8, ovf8, inr8} !== {8'd25, 1'b0, 1'b1}) $display("FAIL drop_retained: got cnt=%0d ovf=%0b inr=%0b want 25/0/1", cnt8, ovf8, inr8);
        else pass++;
    endtask

    task automatic test_reset_mid();
        int  n, e1, raw;
        bit  got;
        apply_reset();
        exp8 = 8'd20; tol8 = 8'd0; exp5 = 5'd20; tol5 = 5'd0;
        per = 5; ph = 0; meas_mode = 1;
        en = 1'b1;
        repeat (W + 1 + 40) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk++;
        if ({cnt8, valid8, inr8, ovf8, busy8} !== 12'd0) $display("FAIL midreset_dut8: got %h want 000", {cnt8, valid8, inr8, ovf8, busy8});
        else pass++;
        chk++;
        if ({cnt5, valid5, inr5, ovf5, busy5} !== 9'd0) $display("FAIL midreset_dut5: got %h want 000", {cnt5, valid5, inr5, ovf5, busy5});
        else pass++;
        meas_mode = 0;
        repeat (3) tick();
        rst_n     = 1'b1;
        meas_mode = 1;
        e1        = cyc;
        n         = 0;
        got       = 1'b0;
        while (!got && n < 3 * W) begin
            tick();
            n++;
            if (valid8 === 1'b1) got = 1'b1;
        end
        chk++;
        if (!got || n + 1 != W + 2) $display("FAIL midreset_latency: got cycle %0d (seen=%0b) want %0d", n + 1, got, W + 2);
        else pass++;
        raw = raw_edges(e1);
        chk++;
        if ({cnt8, ovf8} !== {8'(sat_cnt(raw, 255)), 1'b0}) $display("FAIL midreset_count: got cnt=%0d ovf=%0b want cnt=%0d ovf=0", cnt8, ovf8, raw);
        else pass++;
        en = 1'b0;
    endtask

    task automatic test_edge_last();
        int e0, rel, wi;
        apply_reset();
        exp8 = 8'd1; tol8 = 8'd0; exp5 = 5'd1; tol5 = 5'd0;
        en = 1'b1;
        e0 = cyc;
        pulse_at  = e0 + W - SYNC;
        meas_mode = 2;
        for (int k = 0; k < 3 * (W + 1); k++) begin
            tick();
            rel = (cyc - 1 - e0) % (W + 1);
            wi  = (cyc - 1 - e0) / (W + 1);
            if (wi == 1 && rel == 10) pulse_at = e0 + 2 * (W + 1) - SYNC;
            if (rel == W) begin
                chk++;
                if ({cnt8, inr8} !== {((wi == 0) ? 8'd1 : 8'd0), wi == 0}) $display("FAIL edge_last_dut8 win%0d: got cnt=%0d inr=%0b want cnt=%0d inr=%0b", wi, cnt8, inr8, wi == 0, wi == 0);
                else pass++;
                chk++;
                if ({cnt5, inr5} !== {((wi == 0) ? 5'd1 : 5'd0), wi == 0}) $display("FAIL edge_last_dut5 win%0d: got cnt=%0d inr=%0b want cnt=%0d inr=%0b", wi, cnt5, inr5, wi == 0, wi == 0);
                else pass++;
            end
        end
        en = 1'b0;
        meas_mode = 0;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_zero();
        test_overflow();
        test_back_to_back();
        test_en_drop();
        test_reset_mid();
        test_edge_last();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule

// File: doc/freq_checker.md
FREQ_CHECKER -- requirements
Module: freq_checker

Interface
REQ-001 The block SHALL have parameter WINDOW_CYCLES, default 100000, giving the gate window length in clk cycles (minimum 2).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the edge count and the compare operands.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of meas_in synchroniser flops (minimum 2).
REQ-004 The block SHALL have port clk, input, width 1, as the single clock; all logic is clocked on the posedge.
REQ-005 The block SHALL have port rst_n, input, width 1, as the asynchronous active-low reset.
REQ-006 The block SHALL have port en_in, input, width 1, as the continuous-measurement enable, synchronous to clk.
REQ-007 The block SHALL have port meas_in, input, width 1, as the signal under test; it is asynchronous to clk (divided clock or mux output).
REQ-008 The block SHALL have port expected_in, input, width CNT_W, giving the expected edges per window; it is sampled at window end.
REQ-009 The block SHALL have port tol_in, input, width CNT_W, giving the allowed absolute deviation; it is sampled at window end.
REQ-010 The block SHALL have port count_out, output, width CNT_W, holding the rising-edge count of the last completed window.
REQ-011 The block SHALL have port valid_out, output, width 1, as a one-cycle pulse marking a new result.
REQ-012 The block SHALL have port in_range_out, output, width 1, meaning the last result lies within tolerance.
REQ-013 The block SHALL have port overflow_out, output, width 1, meaning the last window's count saturated.
REQ-014 The block SHALL have port busy_out, output, width 1, which is high while in MEASURE.

Function
REQ-015 meas_in SHALL pass through a SYNC_STAGES flop chain; a rising edge is synced=1 while the registered previous value is 0.
REQ-016 Latency from a meas_in rise to the edge being counted SHALL be SYNC_STAGES+1 clk cycles.
REQ-017 The FSM SHALL have the states IDLE, MEASURE and DONE.
REQ-018 IDLE: when en_in=1, the FSM SHALL go to MEASURE next cycle, loading the window counter with WINDOW_CYCLES-1 and clearing the edge counter and the saturation flag.
REQ-019 MEASURE SHALL last exactly WINDOW_CYCLES cycles; each detected edge increments the edge counter, and an edge in the final cycle is counted.
REQ-020 When the window counter reaches 0 in MEASURE, the FSM SHALL go to DONE.
REQ-021 DONE SHALL last one cycle, during which count_out, overflow_out and in_range_out register the results and valid_out=1.
REQ-022 From DONE, the FSM SHALL go to MEASURE if en_in=1 (back-to-back windows, counter reloaded) and to IDLE otherwise.
REQ-023 Edges detected during DONE or IDLE SHALL be discarded.
REQ-024 If en_in=0 during MEASURE, the FSM SHALL go to IDLE next cycle with no valid_out; count_out, in_range_out and overflow_out hold their previous values.
REQ-025 The edge counter SHALL saturate at 2^CNT_W-1; any edge arriving at saturation sets the saturation flag for that window.
REQ-026 in_range_out SHALL equal (|count - expected_in| <= tol_in), computed at CNT_W+1 bits with no wrap-around.
REQ-027 When overflow is set, in_range_out SHALL be 0.
REQ-028 A change to expected_in or tol_in SHALL affect only results registered at or after the next DONE.

Reset
REQ-029 When rst_n=0, the block SHALL asynchronously force state=IDLE, all synchroniser flops and the edge-detect flop to 0, the counters to 0, count_out=0, valid_out=0, in_range_out=0, overflow_out=0 and busy_out=0.
REQ-030 Reset asserted mid-window SHALL discard the partial count; the first window after release begins only via IDLE with en_in=1.

Structure
REQ-031 Package freq_checker_pkg SHALL hold the state enum typedef freq_state_t (IDLE, MEASURE, DONE).
REQ-032 The synchroniser and rising-edge detector SHALL be the sub-module sync_edge_detect (parameter SYNC_STAGES; ports clk, rst_n, async_in, rise_out).
REQ-033 The RTL SHALL contain no clock gating or derived clocks, and meas_in SHALL never be used as a clock.

Verification (WINDOW_CYCLES=100, CNT_W=8 unless stated)
REQ-034 Scenario: meas_in period 10 cycles, en_in=1, expected_in=10, tol_in=0 -> valid_out pulses every 101 cycles, count_out=10, in_range_out=1, overflow_out=0.
REQ-035 Scenario: meas_in held at 0 -> count_out=0; with expected_in=1 and tol_in=0, in_range_out=0; with tol_in=1, in_range_out=1.
REQ-036 Scenario: meas_in period 2 cycles with CNT_W=5 -> count_out=31, overflow_out=1, in_range_out=0.
REQ-037 Scenario: en_in dropped at MEASURE cycle 50 -> no valid_out, busy_out=0 next cycle, and the previous count_out is retained.
REQ-038 Scenario: rst_n pulsed low mid-window -> all outputs 0 immediately; after release with en_in=1, the first valid_out arrives 102 cycles later.
REQ-039 Scenario: an 8-cycle meas_in pulse placed in the last MEASURE cycle counts 1 in the current window; the same pulse placed in the DONE cycle counts 0.
